// File: rtl/cache_pkg.sv
// cache_pkg: definitions shared by the fully-associative cache and its
// replacement tracker.
//   cache_state_t : controller state encoding
//   clog2()       : index / age counter width for a given line count
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    EVICT  = 3'd2,
    FILL   = 3'd3,
    WMEM   = 3'd4,
    RESP   = 3'd5
  } cache_state_t;

  // Smallest width able to count 0..value-1; used for line indices and ages.
  function automatic int clog2(input int value);
    int result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/lru_tracker.sv
// lru_tracker: keeps one age counter per cache line and picks the line to
// replace on a miss.
// Ports:
//   clk, clr    : clock, asynchronous active-high reset (age of line i = i)
//   touch       : a line was hit or filled this cycle
//   touch_idx   : index of that line
//   valid       : per-line valid bits
//   victim_idx  : lowest-index invalid line, else the oldest line
module lru_tracker
  import cache_pkg::*;
#(
  parameter int N_ENTRIES = 4,
  localparam int IDX_W = clog2(N_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 touch,
  input  logic [IDX_W-1:0]     touch_idx,
  input  logic [N_ENTRIES-1:0] valid,
  output logic [IDX_W-1:0]     victim_idx
);

  logic [IDX_W-1:0] age [N_ENTRIES];
  logic [IDX_W-1:0] touched_age;
  logic             have_invalid;

  assign touched_age = age[touch_idx];

  // The touched line becomes youngest; only lines younger than it age by one,
  // so the set of ages stays a permutation of 0..N_ENTRIES-1.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < N_ENTRIES; i++) age[i] <= IDX_W'(i);
    end else if (touch) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (IDX_W'(i) == touch_idx) age[i] <= '0;
        else if (age[i] < touched_age) age[i] <= age[i] + 1'b1;
      end
    end
  end

  // Empty lines are used first, lowest index winning (the loop runs downward).
  // With every line valid the ages are a permutation, so the oldest line is
  // exactly the one holding N_ENTRIES-1.
  always_comb begin
    victim_idx   = '0;
    have_invalid = 1'b0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        victim_idx   = IDX_W'(i);
        have_invalid = 1'b1;
      end
    end
    if (!have_invalid) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (age[i] == IDX_W'(N_ENTRIES - 1)) victim_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: fully-associative cache with LRU-by-age replacement between a
// CPU request port and a single-outstanding backing memory port.
// Build option: CACHE_WRITE_BACK_EN
//   defined   -> write-back (write hits mark the line dirty, dirty victims are
//                written to memory in EVICT before the fill)
//   undefined -> write-through (every write goes to memory via WMEM; write
//                misses do not allocate)
// Ports:
//   clk, clr                       : clock, asynchronous active-high reset
//   req_valid/req_rw/req_addr/req_wdata, req_ready : CPU request handshake
//   resp_valid/resp_rdata/resp_hit : one-cycle completion, data, hit flag
//   mem_req/mem_rw/mem_addr/mem_wdata : memory request, held until mem_ack
//   mem_ack/mem_rdata              : one-cycle memory completion and read data
module assoc_cache
  import cache_pkg::*;
#(
  parameter int N_ENTRIES = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int IDX_W = clog2(N_ENTRIES);

  cache_state_t state, state_next;

  logic [N_ENTRIES-1:0] line_valid;
  logic [ADDR_W-1:0]    line_tag  [N_ENTRIES];
  logic [DATA_W-1:0]    line_data [N_ENTRIES];
`ifdef CACHE_WRITE_BACK_EN
  logic [N_ENTRIES-1:0] line_dirty;
`endif

  logic              cur_rw;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [IDX_W-1:0]  vic_idx;
  logic [IDX_W-1:0]  victim_idx;
  logic [IDX_W-1:0]  hit_idx;
  logic [IDX_W-1:0]  touch_idx;
  logic              hit;
  logic              touch;

  // The full address is the tag; tags are unique so at most one line matches.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (line_valid[i] && (line_tag[i] == cur_addr)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Ages move on a lookup hit or on the edge that completes a fill.
  assign touch     = ((state == LOOKUP) && hit) || ((state == FILL) && mem_ack);
  assign touch_idx = (state == FILL) ? vic_idx : hit_idx;

  lru_tracker #(.N_ENTRIES(N_ENTRIES)) u_lru (
    .clk        (clk),
    .clr        (clr),
    .touch      (touch),
    .touch_idx  (touch_idx),
    .valid      (line_valid),
    .victim_idx (victim_idx)
  );

  // Controller state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs. Memory outputs derive only from state
  // and registers that do not change while waiting, so they hold until ack.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_req    = 1'b0;
    mem_rw     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
`ifdef CACHE_WRITE_BACK_EN
        if (hit) state_next = RESP;
        else if (line_valid[victim_idx] && line_dirty[victim_idx]) state_next = EVICT;
        else state_next = FILL;
`else
        if (cur_rw) state_next = WMEM;
        else if (hit) state_next = RESP;
        else state_next = FILL;
`endif
      end
      EVICT: begin
        mem_req   = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = line_tag[vic_idx];
        mem_wdata = line_data[vic_idx];
        if (mem_ack) state_next = FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = cur_addr;
        if (mem_ack) state_next = RESP;
      end
      WMEM: begin
        mem_req   = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = cur_addr;
        mem_wdata = cur_wdata;
        if (mem_ack) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, line updates and response registers. The response data
  // is decided in LOOKUP (hit data or write data) and replaced by the memory
  // data only when a read miss completes its fill.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      line_valid <= '0;
`ifdef CACHE_WRITE_BACK_EN
      line_dirty <= '0;
`endif
      for (int i = 0; i < N_ENTRIES; i++) begin
        line_tag[i]  <= '0;
        line_data[i] <= '0;
      end
      cur_rw     <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      vic_idx    <= '0;
      resp_rdata <= '0;
      resp_hit   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cur_rw    <= req_rw;
            cur_addr  <= req_addr;
            cur_wdata <= req_wdata;
          end
        end
        LOOKUP: begin
          vic_idx    <= victim_idx;
          resp_hit   <= hit;
          resp_rdata <= cur_rw ? cur_wdata : line_data[hit_idx];
          if (hit && cur_rw) begin
            line_data[hit_idx] <= cur_wdata;
`ifdef CACHE_WRITE_BACK_EN
            line_dirty[hit_idx] <= 1'b1;
`endif
          end
        end
        EVICT: begin
`ifdef CACHE_WRITE_BACK_EN
          if (mem_ack) line_dirty[vic_idx] <= 1'b0;
`endif
        end
        FILL: begin
          if (mem_ack) begin
            line_valid[vic_idx] <= 1'b1;
            line_tag[vic_idx]   <= cur_addr;
            line_data[vic_idx]  <= cur_rw ? cur_wdata : mem_rdata;
`ifdef CACHE_WRITE_BACK_EN
            line_dirty[vic_idx] <= cur_rw;
`endif
            if (!cur_rw) resp_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed and random checks of assoc_cache against a
// reference memory image, plus random traffic on three other configurations.
module tb_assoc_cache;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_rw = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_hit;
  logic          mem_req;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  assoc_cache #(.N_ENTRIES(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .clr        (clr),
    .req_valid  (req_valid),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_hit   (resp_hit),
    .mem_req    (mem_req),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory as seen by the cache, and the value each address should
  // hold from the CPU's point of view.
  logic [DW-1:0] ext_mem [256];
  logic [DW-1:0] ref_mem [256];

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_txn_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          hit;
    bit            chk_hit;
  } exp_t;

  mem_txn_t mem_log[$];
  exp_t     exp_q[$];
  int       ack_delay = 3;
  bit       hold_ack = 1'b0;
  int       ack_cnt = 0;
  int       mem_req_cycles = 0;
  int       accept_cyc = 0;
  int       last_lat = 0;

  // Memory responder: acks after ack_delay cycles of mem_req, logging every
  // completed transaction.
  always @(negedge clk) begin
    if (mem_req) mem_req_cycles++;
    if (clr) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req && !hold_ack) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) begin
        ack_cnt = 0;
        mem_log.push_back('{mem_rw, mem_addr, mem_wdata});
        if (mem_rw) ext_mem[mem_addr] = mem_wdata;
        else        mem_rdata = ext_mem[mem_addr];
        mem_ack = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"},      req_ready,  1'b1);
    checkOutput({tag, "_resp_valid"}, resp_valid, 1'b0);
    checkOutput({tag, "_resp_hit"},   resp_hit,   1'b0);
    checkOutput({tag, "_resp_rdata"}, resp_rdata, '0);
    checkOutput({tag, "_mem_req"},    mem_req,    1'b0);
    checkOutput({tag, "_mem_rw"},     mem_rw,     1'b0);
    checkOutput({tag, "_mem_addr"},   mem_addr,   '0);
    checkOutput({tag, "_mem_wdata"},  mem_wdata,  '0);
  endtask

  // Drives one request and pushes its expected response onto the scoreboard.
  task automatic applyStimulus(input logic rw, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic exp_hit,
                               input bit chk_hit);
    exp_t e;
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) checkOutput("ready_timeout", req_ready, 1'b1);
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wdata;
    e.rdata   = rw ? wdata : ref_mem[addr];
    e.hit     = exp_hit;
    e.chk_hit = chk_hit;
    if (rw) ref_mem[addr] = wdata;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    req_valid  = 1'b0;
    checkOutput("busy_ready", req_ready, 1'b0);
  endtask

  // Waits for the completion pulse and compares it against the scoreboard.
  task automatic waitResp(input string tag);
    exp_t e;
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!resp_valid && guard < 200);
    if (!resp_valid) begin
      checkOutput({tag, "_timeout"}, resp_valid, 1'b1);
    end else begin
      // +1: the edge that captures resp_valid comes after this negedge.
      last_lat = cyc - accept_cyc + 1;
      e = exp_q.pop_front();
      checkOutput({tag, "_rdata"}, resp_rdata, e.rdata);
      if (e.chk_hit) checkOutput({tag, "_hit"}, resp_hit, e.hit);
    end
  endtask

  task automatic doOp(input logic rw, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic exp_hit,
                      input bit chk_hit, input string tag);
    applyStimulus(rw, addr, wdata, exp_hit, chk_hit);
    waitResp(tag);
  endtask

  task automatic doReset();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_q.delete();
  endtask

  task automatic checkAges(input string tag);
    logic [3:0] seen = '0;
    for (int i = 0; i < 4; i++) seen[dut.u_lru.age[i]] = 1'b1;
    checkOutput(tag, seen, 4'hF);
  endtask

  // Random traffic on wider configurations, each with its own memory image.
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int N = (g == 0) ? 2 : ((g == 1) ? 8 : 16);
    logic        s_clr = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_rw = 1'b0;
    logic [11:0] s_addr = '0;
    logic [15:0] s_wdata = '0;
    logic        s_ready;
    logic        s_resp_valid;
    logic [15:0] s_rdata;
    logic        s_hit;
    logic        s_mem_req;
    logic        s_mem_rw;
    logic [11:0] s_mem_addr;
    logic [15:0] s_mem_wdata;
    logic        s_ack = 1'b0;
    logic [15:0] s_mdata = '0;
    logic [15:0] s_ext [4096];
    logic [15:0] s_ref [4096];
    bit          done = 1'b0;

    assoc_cache #(.N_ENTRIES(N), .ADDR_W(12), .DATA_W(16)) u_dut (
      .clk        (clk),
      .clr        (s_clr),
      .req_valid  (s_valid),
      .req_rw     (s_rw),
      .req_addr   (s_addr),
      .req_wdata  (s_wdata),
      .req_ready  (s_ready),
      .resp_valid (s_resp_valid),
      .resp_rdata (s_rdata),
      .resp_hit   (s_hit),
      .mem_req    (s_mem_req),
      .mem_rw     (s_mem_rw),
      .mem_addr   (s_mem_addr),
      .mem_wdata  (s_mem_wdata),
      .mem_ack    (s_ack),
      .mem_rdata  (s_mdata)
    );

    always @(negedge clk) begin
      if (s_clr) s_ack = 1'b0;
      else if (s_ack) s_ack = 1'b0;
      else if (s_mem_req) begin
        if (s_mem_rw) s_ext[s_mem_addr] = s_mem_wdata;
        else          s_mdata = s_ext[s_mem_addr];
        s_ack = 1'b1;
      end
    end

    initial begin
      int          guard;
      logic [11:0] a;
      logic        rw;
      logic [15:0] wd;
      logic [15:0] exp_d;
      logic [15:0] seen;
      for (int i = 0; i < 4096; i++) begin
        s_ext[i] = 16'(i * 7 + 3);
        s_ref[i] = s_ext[i];
      end
      repeat (2) @(negedge clk);
      s_clr = 1'b0;
      for (int k = 0; k < 120; k++) begin
        a  = 12'($urandom_range(0, 2 * N + 3));
        rw = 1'($urandom_range(0, 1));
        wd = 16'($urandom);
        @(negedge clk);
        guard = 0;
        while (!s_ready && guard < 100) begin
          @(negedge clk);
          guard++;
        end
        s_valid = 1'b1;
        s_rw    = rw;
        s_addr  = a;
        s_wdata = wd;
        exp_d   = rw ? wd : s_ref[a];
        if (rw) s_ref[a] = wd;
        @(posedge clk);
        #1 s_valid = 1'b0;
        guard = 0;
        do begin
          @(negedge clk);
          guard++;
        end while (!s_resp_valid && guard < 100);
        if (!s_resp_valid) checkOutput($sformatf("sweep%0d_timeout", N), s_resp_valid, 1'b1);
        else checkOutput($sformatf("sweep%0d_rdata", N), s_rdata, exp_d);
        if (k % 20 == 19) begin
          seen = '0;
          for (int i = 0; i < N; i++) seen[u_dut.u_lru.age[i]] = 1'b1;
          checkOutput($sformatf("sweep%0d_age_perm", N), seen, 32'((1 << N) - 1));
        end
      end
      done = 1'b1;
    end
  end

  // Directed sequence on the default configuration followed by random traffic.
  initial begin
    int nw;
    int wi;
    int req_before;
    int guard;
    for (int a = 0; a < 256; a++) begin
      ext_mem[a] = 8'(a + 'h95);
      ref_mem[a] = ext_mem[a];
    end
    repeat (3) @(negedge clk);
    checkResetOutputs("rst");
    clr = 1'b0;

    $display("[TB] cold read miss");
    mem_log.delete();
    ack_delay = 3;
    doOp(1'b0, 8'h10, 8'h00, 1'b0, 1'b1, "miss10");
    checkOutput("miss10_memcnt", mem_log.size(), 1);
    if (mem_log.size() > 0) begin
      checkOutput("miss10_memaddr", mem_log[0].addr, 8'h10);
      checkOutput("miss10_memrw",   mem_log[0].rw,   1'b0);
    end

    $display("[TB] read hit latency");
    req_before = mem_req_cycles;
    doOp(1'b0, 8'h10, 8'h00, 1'b1, 1'b1, "hit10");
    checkOutput("hit10_latency", last_lat, 2);
    checkOutput("hit10_no_mem", mem_req_cycles - req_before, 0);

    $display("[TB] LRU replacement");
    doReset();
    ack_delay = 1;
    for (int a = 1; a <= 4; a++) doOp(1'b0, 8'(a), 8'h00, 1'b0, 1'b1, "fill");
    doOp(1'b0, 8'h01, 8'h00, 1'b1, 1'b1, "lru_touch01");
    doOp(1'b0, 8'h05, 8'h00, 1'b0, 1'b1, "lru_miss05");
    doOp(1'b0, 8'h01, 8'h00, 1'b1, 1'b1, "lru_keep01");
    doOp(1'b0, 8'h02, 8'h00, 1'b0, 1'b1, "lru_gone02");
    checkAges("lru_age_perm");

    $display("[TB] write hit and eviction");
    mem_log.delete();
    doOp(1'b1, 8'h01, 8'h5A, 1'b1, 1'b1, "whit01");
`ifdef CACHE_WRITE_BACK_EN
    checkOutput("wb_whit_memcnt", mem_log.size(), 0);
`else
    checkOutput("wt_whit_memcnt", mem_log.size(), 1);
    if (mem_log.size() > 0) begin
      checkOutput("wt_whit_rw",    mem_log[0].rw,    1'b1);
      checkOutput("wt_whit_addr",  mem_log[0].addr,  8'h01);
      checkOutput("wt_whit_wdata", mem_log[0].wdata, 8'h5A);
    end
`endif
    mem_log.delete();
    for (int a = 'h40; a < 'h44; a++) doOp(1'b0, 8'(a), 8'h00, 1'b0, 1'b1, "evict_fill");
    nw = 0;
    wi = -1;
    foreach (mem_log[i]) begin
      if (mem_log[i].rw) begin
        nw++;
        wi = i;
      end
    end
`ifdef CACHE_WRITE_BACK_EN
    checkOutput("wb_evict_wcount", nw, 1);
    if (wi >= 0) begin
      checkOutput("wb_evict_addr",  mem_log[wi].addr,  8'h01);
      checkOutput("wb_evict_wdata", mem_log[wi].wdata, 8'h5A);
      if (wi + 1 < mem_log.size()) checkOutput("wb_evict_then_fill", mem_log[wi + 1].rw, 1'b0);
      else checkOutput("wb_evict_then_fill", mem_log.size(), wi + 2);
    end
`else
    checkOutput("wt_evict_wcount", nw, 0);
`endif
    doOp(1'b0, 8'h01, 8'h00, 1'b0, 1'b1, "reread01");

    $display("[TB] reset during fill");
    doReset();
    hold_ack = 1'b1;
    applyStimulus(1'b0, 8'h30, 8'h00, 1'b0, 1'b1);
    guard = 0;
    while (!mem_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("clrfill_req",  mem_req,  1'b1);
    checkOutput("clrfill_addr", mem_addr, 8'h30);
    clr = 1'b1;
    @(negedge clk);
    checkResetOutputs("clrfill");
    clr = 1'b0;
    hold_ack = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkOutput("clrfill_idle_mem_req", mem_req, 1'b0);
    doOp(1'b0, 8'h30, 8'h00, 1'b0, 1'b1, "clrfill_reread");

    $display("[TB] random traffic");
    doReset();
    ack_delay = 2;
    for (int k = 0; k < 150; k++) begin
      doOp(1'($urandom_range(0, 1)), 8'($urandom_range(0, 11)), 8'($urandom),
           1'b0, 1'b0, "rand");
      if (k % 25 == 24) checkAges("rand_age_perm");
    end

    guard = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && guard < 50000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("sweep_done",
                {g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}, 3'b111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
